// File: rtl/graph_loader.sv
// graph_loader: buffers edge-weight updates into the adjacency matrix and runs
// the optional adjmat clear plus Bellman-Ford vertex initialisation.
module graph_loader #(
  parameter int NODES        = 8,
  parameter int PRED_WIDTH   = 2,
  parameter int WEIGHT_WIDTH = 15,
  parameter int VERT_WIDTH   = PRED_WIDTH + WEIGHT_WIDTH + 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    edge_valid,
  output logic                    edge_ready,
  input  logic [PRED_WIDTH:0]     edge_src,
  input  logic [PRED_WIDTH:0]     edge_dst,
  input  logic [WEIGHT_WIDTH:0]   edge_weight,
  input  logic                    init_start,
  input  logic                    init_clear_adj,
  input  logic [PRED_WIDTH:0]     init_source,
  output logic                    busy,
  output logic                    init_done,
  output logic                    edge_drop,
  output logic [15:0]             edges_written,
  output logic [VERT_WIDTH:0]     vertmat_data,
  output logic [PRED_WIDTH:0]     vertmat_addr,
  output logic                    vertmat_we,
  output logic [WEIGHT_WIDTH:0]   adjmat_data,
  output logic [PRED_WIDTH:0]     adjmat_row_addr,
  output logic [PRED_WIDTH:0]     adjmat_col_addr,
  output logic                    adjmat_we
);
  localparam int IW = PRED_WIDTH + 1;
  localparam int WW = WEIGHT_WIDTH + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [IW:0]    NODES_W = (IW+1)'(NODES);
  localparam logic [IW-1:0]  LAST    = IW'(NODES - 1);
  localparam logic [WW-1:0]  INF     = {1'b0, {WEIGHT_WIDTH{1'b1}}};
  localparam logic [AW:0]    FULL    = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR_ADJ, INIT_VERT, DONE} state_t;
  state_t r_state, w_next;

  logic [2*IW+WW-1:0] r_fifo [FIFO_DEPTH];
  logic [AW-1:0]      r_wp, r_rp;
  logic [AW:0]        r_cnt, w_cnt;
  logic [IW-1:0]      r_row, r_col, r_src;
  logic [IW-1:0]      w_hsrc, w_hdst;
  logic [WW-1:0]      w_hw;
  logic               w_push, w_pop, w_bad, w_last_row, w_last_col;

  assign w_push     = edge_valid && edge_ready;
  assign w_pop      = r_state == IDLE && !init_start && r_cnt != '0;
  assign {w_hsrc, w_hdst, w_hw} = r_fifo[r_rp];
  assign w_bad      = {1'b0, w_hsrc} >= NODES_W || {1'b0, w_hdst} >= NODES_W || w_hsrc == w_hdst;
  assign w_cnt      = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_last_row = r_row == LAST;
  assign w_last_col = r_col == LAST;
  assign busy       = r_state != IDLE;
  assign init_done  = r_state == DONE;

  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = !init_start ? IDLE : init_clear_adj ? CLEAR_ADJ : INIT_VERT;
      CLEAR_ADJ: w_next = (w_last_row && w_last_col) ? INIT_VERT : CLEAR_ADJ;
      INIT_VERT: w_next = w_last_col ? DONE : INIT_VERT;
      default:   w_next = IDLE;
    endcase
  end

  // storage needs no reset: occupancy is tracked by the pointers
  always_ff @(posedge clk)
    if (w_push) r_fifo[r_wp] <= {edge_src, edge_dst, edge_weight};

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wp            <= '0;
      r_rp            <= '0;
      r_cnt           <= '0;
      edge_ready      <= 1'b1;
      r_row           <= '0;
      r_col           <= '0;
      r_src           <= '0;
      edge_drop       <= 1'b0;
      edges_written   <= '0;
      adjmat_we       <= 1'b0;
      adjmat_data     <= '0;
      adjmat_row_addr <= '0;
      adjmat_col_addr <= '0;
      vertmat_we      <= 1'b0;
      vertmat_data    <= '0;
      vertmat_addr    <= '0;
    end else begin
      adjmat_we  <= 1'b0;
      vertmat_we <= 1'b0;
      edge_drop  <= 1'b0;
      r_cnt      <= w_cnt;
      edge_ready <= w_cnt != FULL;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp      <= r_rp + 1'b1;
        edge_drop <= w_bad;
        adjmat_we <= !w_bad;
        if (!w_bad) begin
          adjmat_row_addr <= w_hsrc;
          adjmat_col_addr <= w_hdst;
          adjmat_data     <= w_hw;
          edges_written   <= edges_written + {15'd0, edges_written != 16'hFFFF};
        end
      end
      if (r_state == IDLE && init_start) begin
        r_src <= init_source;
        r_row <= '0;
        r_col <= '0;
      end
      if (r_state == CLEAR_ADJ) begin
        adjmat_we       <= 1'b1;
        adjmat_row_addr <= r_row;
        adjmat_col_addr <= r_col;
        adjmat_data     <= '0;
        r_col           <= w_last_col ? '0 : r_col + 1'b1;
        r_row           <= !w_last_col ? r_row : w_last_row ? '0 : r_row + 1'b1;
      end
      if (r_state == INIT_VERT) begin
        vertmat_we   <= 1'b1;
        vertmat_addr <= r_col;
        vertmat_data <= {1'b0, r_col, r_col == r_src ? '0 : INF};
        r_col        <= w_last_col ? '0 : r_col + 1'b1;
      end
    end
endmodule

// File: tb/tb_graph_loader.sv
// tb_graph_loader: directed scenarios for graph_loader with a negedge write monitor.
module tb_graph_loader;
  logic        clk = 1'b0, reset = 1'b1, edge_valid = 1'b0;
  logic [2:0]  edge_src = '0, edge_dst = '0, init_source = '0;
  logic [15:0] edge_weight = '0;
  logic        init_start = 1'b0, init_clear_adj = 1'b0;
  logic        edge_ready, busy, init_done, edge_drop, vertmat_we, adjmat_we;
  logic [15:0] edges_written, adjmat_data;
  logic [19:0] vertmat_data;
  logic [2:0]  vertmat_addr, adjmat_row_addr, adjmat_col_addr;

  graph_loader dut (
    .clk(clk), .reset(reset), .edge_valid(edge_valid), .edge_ready(edge_ready),
    .edge_src(edge_src), .edge_dst(edge_dst), .edge_weight(edge_weight),
    .init_start(init_start), .init_clear_adj(init_clear_adj), .init_source(init_source),
    .busy(busy), .init_done(init_done), .edge_drop(edge_drop), .edges_written(edges_written),
    .vertmat_data(vertmat_data), .vertmat_addr(vertmat_addr), .vertmat_we(vertmat_we),
    .adjmat_data(adjmat_data), .adjmat_row_addr(adjmat_row_addr),
    .adjmat_col_addr(adjmat_col_addr), .adjmat_we(adjmat_we)
  );

  always #5 clk = ~clk;

  int cmp = 0, bad = 0, cyc = 0, last_acc = 0;
  logic [21:0] aq[$];
  int          acq[$];
  logic [22:0] vq[$];
  int both = 0, drops = 0, busy_cyc = 0, done_cnt = 0, done_cyc = 0, adj_busy = 0, nr_busy = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (!reset) begin
      if (adjmat_we) begin
        aq.push_back({adjmat_row_addr, adjmat_col_addr, adjmat_data});
        acq.push_back(cyc);
        if (busy) adj_busy++;
      end
      if (vertmat_we) vq.push_back({vertmat_addr, vertmat_data});
      if (adjmat_we && vertmat_we) both++;
      if (edge_drop) drops++;
      if (busy) busy_cyc++;
      if (busy && !edge_ready) nr_busy++;
      if (init_done) begin done_cnt++; done_cyc = cyc; end
    end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [2:0] s, input logic [2:0] d, input logic [15:0] w);
    logic r;
    int n = 0;
    edge_valid = 1'b1; edge_src = s; edge_dst = d; edge_weight = w;
    do begin r = edge_ready; @(negedge clk); n++; end while (!r && n < 300);
    cmp++;
    if (!r) begin bad++; $display("FAIL send_timeout: ready got 0 want 1 for %0d/%0d", s, d); end
    last_acc = cyc;
  endtask

  task automatic start_init(input logic clr, input logic [2:0] src);
    init_clear_adj = clr; init_source = src; init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!init_done && n < 300) begin @(negedge clk); n++; end
    cmp++;
    if (!init_done) begin bad++; $display("FAIL init_timeout: init_done got 0 want 1"); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    cmp++; if (edge_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", edge_ready); end
    cmp++; if (adjmat_we !== 1'b0) begin bad++; $display("FAIL rst_adj_we: got %b want 0", adjmat_we); end
    cmp++; if (vertmat_we !== 1'b0) begin bad++; $display("FAIL rst_vert_we: got %b want 0", vertmat_we); end
    cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    cmp++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", init_done); end
    cmp++; if (edge_drop !== 1'b0) begin bad++; $display("FAIL rst_drop: got %b want 0", edge_drop); end
    cmp++; if (edges_written !== 16'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", edges_written); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_single();
    int b = aq.size();
    send(3'd1, 3'd2, 16'hFFFB);
    edge_valid = 1'b0;
    idle(4);
    cmp++; if (aq.size() != b + 1) begin bad++; $display("FAIL single_nwrites: got %0d want 1", aq.size() - b); end
    cmp++; if (aq[b] !== {3'd1, 3'd2, 16'hFFFB}) begin bad++; $display("FAIL single_write: got %h want %h", aq[b], {3'd1, 3'd2, 16'hFFFB}); end
    cmp++; if (acq[b] != last_acc + 1) begin bad++; $display("FAIL single_latency: got cycle %0d want %0d", acq[b], last_acc + 1); end
    cmp++; if (edges_written !== 16'd1) begin bad++; $display("FAIL single_count: got %0d want 1", edges_written); end
    cmp++; if (edge_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", edge_ready); end
  endtask

  task automatic test_back_to_back();
    logic [21:0] v [6] = '{{3'd0, 3'd1, 16'd10}, {3'd1, 3'd0, 16'hFFFF}, {3'd2, 3'd3, 16'd100},
                           {3'd3, 3'd4, 16'h8000}, {3'd5, 3'd7, 16'h7FFF}, {3'd0, 3'd1, 16'd20}};
    int b = aq.size();
    int e = 0;
    for (int i = 0; i < 6; i++) send(v[i][21:19], v[i][18:16], v[i][15:0]);
    edge_valid = 1'b0;
    idle(5);
    cmp++; if (aq.size() != b + 6) begin bad++; $display("FAIL b2b_nwrites: got %0d want 6", aq.size() - b); end
    for (int i = 0; i < 6; i++) if (aq[b+i] !== v[i] || acq[b+i] != acq[b] + i) e++;
    cmp++; if (e != 0) begin bad++; $display("FAIL b2b_order: got %0d bad entries want 0", e); end
    cmp++; if (edges_written !== 16'd7) begin bad++; $display("FAIL b2b_count: got %0d want 7", edges_written); end
  endtask

  task automatic test_init_clear();
    int ab = aq.size(), vb = vq.size(), bc = busy_cyc, dc = done_cnt, bo = both;
    int e = 0, ev = 0;
    logic [21:0] ex;
    logic [22:0] vx;
    start_init(1'b1, 3'd3);
    cmp++; if (busy !== 1'b1) begin bad++; $display("FAIL clr_busy_start: got %b want 1", busy); end
    wait_done();
    idle(3);
    cmp++; if (aq.size() != ab + 64) begin bad++; $display("FAIL clr_nwrites: got %0d want 64", aq.size() - ab); end
    for (int i = 0; i < 64; i++) begin ex = {3'(i / 8), 3'(i % 8), 16'd0}; if (aq[ab+i] !== ex) e++; end
    cmp++; if (e != 0) begin bad++; $display("FAIL clr_order: got %0d bad entries want 0", e); end
    cmp++; if (vq.size() != vb + 8) begin bad++; $display("FAIL clr_nvert: got %0d want 8", vq.size() - vb); end
    for (int i = 0; i < 8; i++) begin vx = {3'(i), 1'b0, 3'(i), (i == 3) ? 16'h0000 : 16'h7FFF}; if (vq[vb+i] !== vx) ev++; end
    cmp++; if (ev != 0) begin bad++; $display("FAIL clr_vert: got %0d bad entries want 0", ev); end
    cmp++; if (busy_cyc - bc != 73) begin bad++; $display("FAIL clr_busy_len: got %0d want 73", busy_cyc - bc); end
    cmp++; if (done_cnt - dc != 1) begin bad++; $display("FAIL clr_done_pulses: got %0d want 1", done_cnt - dc); end
    cmp++; if (both != bo) begin bad++; $display("FAIL clr_overlap: got %0d want 0", both - bo); end
    cmp++; if (edges_written !== 16'd7) begin bad++; $display("FAIL clr_count: got %0d want 7", edges_written); end
    cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_init_fifo();
    logic [21:0] v [6] = '{{3'd6, 3'd1, 16'd1}, {3'd1, 3'd6, 16'd2}, {3'd2, 3'd5, 16'hFFF0},
                           {3'd3, 3'd2, 16'd4}, {3'd4, 3'd0, 16'd5}, {3'd7, 3'd3, 16'd6}};
    int ab = aq.size(), vb = vq.size(), abz = adj_busy, nrb = nr_busy;
    int e = 0, ev = 0, n = 0;
    logic [22:0] vx;
    start_init(1'b0, 3'd5);
    for (int i = 0; i < 6; i++) send(v[i][21:19], v[i][18:16], v[i][15:0]);
    edge_valid = 1'b0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    idle(8);
    cmp++; if (adj_busy != abz) begin bad++; $display("FAIL fifo_busy_writes: got %0d want 0", adj_busy - abz); end
    cmp++; if (nr_busy == nrb) begin bad++; $display("FAIL fifo_full: got ready always 1 want a drop to 0"); end
    cmp++; if (aq.size() != ab + 6) begin bad++; $display("FAIL fifo_nwrites: got %0d want 6", aq.size() - ab); end
    for (int i = 0; i < 6; i++) if (aq[ab+i] !== v[i]) e++;
    cmp++; if (e != 0) begin bad++; $display("FAIL fifo_order: got %0d bad entries want 0", e); end
    cmp++; if (acq[ab] <= done_cyc) begin bad++; $display("FAIL fifo_after_done: got cycle %0d want > %0d", acq[ab], done_cyc); end
    for (int i = 0; i < 8; i++) begin vx = {3'(i), 1'b0, 3'(i), (i == 5) ? 16'h0000 : 16'h7FFF}; if (vq[vb+i] !== vx) ev++; end
    cmp++; if (vq.size() != vb + 8 || ev != 0) begin bad++; $display("FAIL fifo_vert: got %0d writes %0d bad want 8 0", vq.size() - vb, ev); end
    cmp++; if (edges_written !== 16'd13) begin bad++; $display("FAIL fifo_count: got %0d want 13", edges_written); end
  endtask

  task automatic test_drop();
    int b = aq.size(), d = drops;
    send(3'd4, 3'd4, 16'd7);
    edge_valid = 1'b0;
    idle(4);
    cmp++; if (drops - d != 1) begin bad++; $display("FAIL drop_pulse: got %0d want 1", drops - d); end
    cmp++; if (aq.size() != b) begin bad++; $display("FAIL drop_nowrite: got %0d want 0", aq.size() - b); end
    cmp++; if (edges_written !== 16'd13) begin bad++; $display("FAIL drop_count: got %0d want 13", edges_written); end
    send(3'd2, 3'd6, 16'd0);
    edge_valid = 1'b0;
    idle(4);
    cmp++; if (aq.size() != b + 1 || aq[b] !== {3'd2, 3'd6, 16'd0}) begin bad++; $display("FAIL delete_write: got %h want %h", aq[b], {3'd2, 3'd6, 16'd0}); end
    cmp++; if (edges_written !== 16'd14) begin bad++; $display("FAIL delete_count: got %0d want 14", edges_written); end
  endtask

  task automatic test_reset_mid();
    int ab, vb, e = 0, ev = 0;
    logic [21:0] ex;
    logic [22:0] vx;
    start_init(1'b1, 3'd0);
    send(3'd3, 3'd4, 16'd9);
    send(3'd4, 3'd3, 16'd8);
    edge_valid = 1'b0;
    idle(20);
    #2 reset = 1'b1;
    #1;
    cmp++; if (adjmat_we !== 1'b0 || vertmat_we !== 1'b0) begin bad++; $display("FAIL mid_we: got %b%b want 00", adjmat_we, vertmat_we); end
    cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    cmp++; if (edge_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", edge_ready); end
    cmp++; if (edges_written !== 16'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", edges_written); end
    @(negedge clk);
    reset = 1'b0;
    ab = aq.size();
    idle(5);
    cmp++; if (aq.size() != ab) begin bad++; $display("FAIL mid_fifo_empty: got %0d writes want 0", aq.size() - ab); end
    vb = vq.size();
    start_init(1'b1, 3'd0);
    wait_done();
    idle(3);
    for (int i = 0; i < 64; i++) begin ex = {3'(i / 8), 3'(i % 8), 16'd0}; if (aq[ab+i] !== ex) e++; end
    cmp++; if (aq.size() != ab + 64 || e != 0) begin bad++; $display("FAIL mid_reclear: got %0d writes %0d bad want 64 0", aq.size() - ab, e); end
    for (int i = 0; i < 8; i++) begin vx = {3'(i), 1'b0, 3'(i), (i == 0) ? 16'h0000 : 16'h7FFF}; if (vq[vb+i] !== vx) ev++; end
    cmp++; if (vq.size() != vb + 8 || ev != 0) begin bad++; $display("FAIL mid_revert: got %0d writes %0d bad want 8 0", vq.size() - vb, ev); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_init_clear();
    test_init_fifo();
    test_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
